conv_column_streamer: RTL and testbench

- Parametrised column-feed front end for the convolution array.
- Fetches image columns from the packed FP16 feature memory: BUS_WIDTH-bit words, several pixels per word.
- Assembles each column into a buffer with zero padding and presents it to the parallel conv engines over a valid/ready handshake.
- Adds multi-channel sequencing, padding columns, stride-aligned window flags and downstream backpressure.

---
 rtl/conv_column_streamer_if.sv | 33 +++
 rtl/conv_column_streamer.sv | 179 +++++++++++++++++
 tb/tb_conv_column_streamer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_column_streamer_if.sv
// Column stream from the streamer to the conv engines.
// Widths derive from the same geometry parameters as the streamer.
interface conv_column_streamer_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_SIZE   = 28,
  parameter int KERNEL_SIZE  = 5,
  parameter int PADDING      = 0,
  parameter int STRIDE       = 1,
  parameter int NUM_CHANNELS = 1
);
  localparam int PADDED   = IMAGE_SIZE + 2 * PADDING;
  localparam int OUT_COLS = (PADDED - KERNEL_SIZE) / STRIDE + 1;

  logic [PADDED*DATA_WIDTH-1:0]    col_data;
  logic                            col_valid;
  logic                            col_ready;
  logic [$clog2(PADDED):0]         col_idx;
  logic [$clog2(NUM_CHANNELS):0]   col_channel;
  logic                            window_valid;
  logic [$clog2(OUT_COLS):0]       out_col;

  modport master (
    output col_data, col_valid, col_idx,
    output col_channel, window_valid, out_col,
    input  col_ready
  );

  modport slave (
    input  col_data, col_valid, col_idx,
    input  col_channel, window_valid, out_col,
    output col_ready
  );
endinterface

// File: rtl/conv_column_streamer.sv
// Fetches packed image columns, zero-pads them and streams
// one column per handshake to the convolution array.
module conv_column_streamer #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_SIZE   = 28,
  parameter int KERNEL_SIZE  = 5,
  parameter int PADDING      = 0,
  parameter int STRIDE       = 1,
  parameter int NUM_CHANNELS = 1,
  parameter int BUS_WIDTH    = 256,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BUS_WIDTH-1:0]  mem_rd_data,
  conv_column_streamer_if.master col,
  output logic                  busy,
  output logic                  done
);
  localparam int PPW      = BUS_WIDTH / DATA_WIDTH;
  localparam int WPC      = (IMAGE_SIZE + PPW - 1) / PPW;
  localparam int PADDED   = IMAGE_SIZE + 2 * PADDING;
  localparam int OUT_COLS = (PADDED - KERNEL_SIZE) / STRIDE + 1;
  localparam int CW = $clog2(PADDED) + 1;
  localparam int HW = $clog2(NUM_CHANNELS) + 1;
  localparam int OW = $clog2(OUT_COLS) + 1;
  localparam int WW = $clog2(WPC) + 1;
  localparam int SW = $clog2(STRIDE) + 1;

  generate
    if (BUS_WIDTH % DATA_WIDTH != 0) begin : g_err_bus
      $error("BUS_WIDTH must be a multiple of DATA_WIDTH");
    end
    if (KERNEL_SIZE > PADDED) begin : g_err_kernel
      $error("KERNEL_SIZE exceeds padded image size");
    end
    if (longint'(NUM_CHANNELS) * IMAGE_SIZE * WPC >
        (longint'(1) << ADDR_WIDTH)) begin : g_err_addr
      $error("feature memory exceeds ADDR_WIDTH");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_PRESENT, S_FINISH
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         col_q;
  logic [HW-1:0]         ch_q;
  logic [WW-1:0]         word_q;
  logic [WW-1:0]         cap_word;
  logic                  cap_en;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SW-1:0]         phase_q;
  logic [OW-1:0]         ocnt_q;
  logic [DATA_WIDTH-1:0] rows [PADDED];
  logic is_img, last_word, last_col, last_ch;
  logic past_k, at_win, hs, clr;

  // Unsigned wrap makes left pad columns land above IMAGE_SIZE.
  assign is_img    = (col_q - CW'(PADDING)) < CW'(IMAGE_SIZE);
  assign last_word = word_q == WW'(WPC - 1);
  assign last_col  = col_q == CW'(PADDED - 1);
  assign last_ch   = ch_q == HW'(NUM_CHANNELS - 1);
  assign past_k    = col_q >= CW'(KERNEL_SIZE - 1);
  assign at_win    = past_k && (phase_q == '0);
  assign hs        = col.col_valid && col.col_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    mem_rd_en     = 1'b0;
    col.col_valid = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    clr           = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (is_img) begin
          mem_rd_en = 1'b1;
          if (last_word) state_n = S_CAPTURE;
        end else begin
          clr     = 1'b1;
          state_n = S_PRESENT;
        end
      end
      S_CAPTURE: state_n = S_PRESENT;
      S_PRESENT: begin
        col.col_valid = 1'b1;
        if (col.col_ready)
          state_n = (last_col && last_ch) ? S_FINISH
                                          : S_FETCH;
      end
      S_FINISH: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mem_addr         = mem_rd_en ? addr_q : '0;
  assign col.col_idx      = col_q;
  assign col.col_channel  = ch_q;
  assign col.window_valid = col.col_valid && at_win;
  assign col.out_col      = col.window_valid ? ocnt_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      ch_q     <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      phase_q  <= '0;
      ocnt_q   <= '0;
      cap_en   <= 1'b0;
      cap_word <= '0;
    end else begin
      cap_en   <= mem_rd_en;
      cap_word <= word_q;
      if (state == S_IDLE && start) begin
        col_q   <= '0;
        ch_q    <= '0;
        word_q  <= '0;
        addr_q  <= '0;
        phase_q <= '0;
        ocnt_q  <= '0;
      end
      if (mem_rd_en) begin
        addr_q <= addr_q + 1'b1;
        word_q <= last_word ? '0 : word_q + 1'b1;
      end
      if (hs) begin
        if (last_col) begin
          col_q   <= '0;
          ch_q    <= last_ch ? '0 : ch_q + 1'b1;
          phase_q <= '0;
          ocnt_q  <= '0;
        end else begin
          col_q <= col_q + 1'b1;
          // Stride phase replaces a modulo on the column index.
          if (past_k)
            phase_q <= (phase_q == SW'(STRIDE - 1))
                       ? '0 : phase_q + 1'b1;
          if (at_win) ocnt_q <= ocnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < PADDED; r++) rows[r] <= '0;
    end else if (clr) begin
      for (int r = 0; r < PADDED; r++) rows[r] <= '0;
    end else if (cap_en) begin
      for (int r = 0; r < IMAGE_SIZE; r++)
        if (cap_word == WW'(r / PPW))
          rows[PADDING+r] <=
            mem_rd_data[(r % PPW)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar r = 0; r < PADDED; r++) begin : g_col
    assign col.col_data[r*DATA_WIDTH +: DATA_WIDTH] = rows[r];
  end
endmodule

// File: tb/tb_conv_column_streamer.sv
// Directed bench: default geometry plus a padded, strided,
// three-channel instance, each fed from a behavioural memory.
module tb_conv_column_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         a_start, a_rd_en, a_busy, a_done;
  logic [11:0]  a_addr;
  logic [255:0] a_rd_data;
  conv_column_streamer_if #(
    .DATA_WIDTH(16), .IMAGE_SIZE(28), .KERNEL_SIZE(5),
    .PADDING(0), .STRIDE(1), .NUM_CHANNELS(1)
  ) ca ();
  conv_column_streamer #(
    .DATA_WIDTH(16), .IMAGE_SIZE(28), .KERNEL_SIZE(5),
    .PADDING(0), .STRIDE(1), .NUM_CHANNELS(1),
    .BUS_WIDTH(256), .ADDR_WIDTH(12)
  ) dut_a (
    .clk(clk), .rst(rst), .start(a_start),
    .mem_rd_en(a_rd_en), .mem_addr(a_addr),
    .mem_rd_data(a_rd_data), .col(ca),
    .busy(a_busy), .done(a_done)
  );

  logic         b_start, b_rd_en, b_busy, b_done;
  logic [11:0]  b_addr;
  logic [255:0] b_rd_data;
  conv_column_streamer_if #(
    .DATA_WIDTH(16), .IMAGE_SIZE(28), .KERNEL_SIZE(5),
    .PADDING(1), .STRIDE(2), .NUM_CHANNELS(3)
  ) cb ();
  conv_column_streamer #(
    .DATA_WIDTH(16), .IMAGE_SIZE(28), .KERNEL_SIZE(5),
    .PADDING(1), .STRIDE(2), .NUM_CHANNELS(3),
    .BUS_WIDTH(256), .ADDR_WIDTH(12)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start),
    .mem_rd_en(b_rd_en), .mem_addr(b_addr),
    .mem_rd_data(b_rd_data), .col(cb),
    .busy(b_busy), .done(b_done)
  );

  function automatic logic [15:0] pix(int c, int x, int y);
    return 16'((c << 13) | (x << 8) | y);
  endfunction

  // Memory layout: channel-major, column-major, two words per column.
  function automatic logic [255:0] mem_word(int addr);
    logic [255:0] d;
    int c = addr / 56;
    int x = (addr / 2) % 28;
    int w = addr % 2;
    for (int j = 0; j < 16; j++) begin
      int y = w * 16 + j;
      d[j*16 +: 16] = (y < 28) ? pix(c, x, y) : 16'hDEAD;
    end
    return d;
  endfunction

  function automatic logic [479:0] exp_col(int c, int k, int pad);
    logic [479:0] d = '0;
    for (int r = 0; r < 28 + 2 * pad; r++)
      if (r >= pad && r < pad + 28 && k >= pad && k < pad + 28)
        d[r*16 +: 16] = pix(c, k - pad, r - pad);
    return d;
  endfunction

  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? mem_word(int'(a_addr)) : {16{16'hBEEF}};
    b_rd_data <= b_rd_en ? mem_word(int'(b_addr)) : {16{16'hBEEF}};
  end

  typedef struct {
    int col; int ch; bit wv; int oc;
    logic [479:0] data; int cyc;
  } obs_t;
  typedef struct { int addr; int col; int ch; } rd_t;
  typedef struct { int col; int ch; bit wv; int oc; int pad; } vec_t;

  obs_t a_cols[$];
  obs_t b_cols[$];
  int   a_addrs[$];
  rd_t  b_reads[$];
  int   a_done_n = 0, a_done_cyc = 0, b_done_n = 0;
  int   a_c0, a_r0, a_d0;
  vec_t va[$];
  vec_t vb[$];

  always @(negedge clk) begin
    if (ca.col_valid && ca.col_ready)
      a_cols.push_back('{int'(ca.col_idx), int'(ca.col_channel),
        ca.window_valid, int'(ca.out_col), 480'(ca.col_data), cyc});
    if (a_rd_en) a_addrs.push_back(int'(a_addr));
    if (a_done) begin a_done_n++; a_done_cyc = cyc; end
    if (cb.col_valid && cb.col_ready)
      b_cols.push_back('{int'(cb.col_idx), int'(cb.col_channel),
        cb.window_valid, int'(cb.out_col), cb.col_data, cyc});
    if (b_rd_en)
      b_reads.push_back('{int'(b_addr), int'(cb.col_idx),
        int'(cb.col_channel)});
    if (b_done) b_done_n++;
  end

  task automatic chk(input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a();
    tick(); a_start = 1'b1;
    tick(); a_start = 1'b0;
  endtask

  task automatic mark_a();
    a_c0 = a_cols.size();
    a_r0 = a_addrs.size();
    a_d0 = a_done_n;
  endtask

  task automatic wait_a_done(input string tag);
    for (int i = 0; i < 600 && a_done_n == a_d0; i++) tick();
    repeat (3) tick();
    chk({tag, " done_count"}, a_done_n - a_d0, 1);
  endtask

  task automatic verify_a(input string tag);
    int n = a_cols.size() - a_c0;
    int m = a_addrs.size() - a_r0;
    chk({tag, " ncols"}, n, va.size());
    for (int i = 0; i < va.size() && i < n; i++) begin
      obs_t o = a_cols[a_c0 + i];
      chk($sformatf("%s col%0d meta", tag, i),
          {o.ch, o.col, o.wv, o.wv ? o.oc : 0},
          {va[i].ch, va[i].col, va[i].wv, va[i].wv ? va[i].oc : 0});
      chk($sformatf("%s col%0d data", tag, i), o.data,
          exp_col(va[i].ch, va[i].col, 0));
    end
    chk({tag, " nreads"}, m, 56);
    for (int i = 0; i < m && i < 56; i++)
      chk($sformatf("%s addr%0d", tag, i), a_addrs[a_r0 + i], i);
    if (n > 0)
      chk({tag, " done_lat"},
          a_done_cyc - a_cols[a_cols.size()-1].cyc, 1);
  endtask

  initial begin
    int n;
    int f;
    int e;
    for (int k = 0; k < 28; k++)
      va.push_back('{k, 0, k >= 4, (k >= 4) ? k - 4 : 0, 0});
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 30; k++)
        vb.push_back('{k, c, (k >= 4) && ((k - 4) % 2 == 0),
                       (k >= 4) ? (k - 4) / 2 : 0, 1});

    rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    ca.col_ready = 1'b1; cb.col_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a ctl", {a_rd_en, a_addr, ca.col_valid, ca.col_idx,
        ca.col_channel, ca.window_valid, ca.out_col, a_busy, a_done}, '0);
    chk("reset_a data", ca.col_data, '0);
    chk("reset_b ctl", {b_rd_en, b_addr, cb.col_valid, cb.col_idx,
        cb.col_channel, cb.window_valid, cb.out_col, b_busy, b_done}, '0);
    rst = 1'b0;

    // Frame 1: default geometry, consumer always ready.
    mark_a();
    pulse_a();
    n = 1;
    while (!ca.col_valid && n < 50) begin tick(); n++; end
    chk("first_latency", n, 4);
    wait_a_done("f1");
    verify_a("f1");

    // Frame 2: stall column 10, stray start while busy.
    mark_a();
    pulse_a();
    for (int i = 0; i < 200 && ca.col_idx != 5; i++) tick();
    chk("f2 reach col5", ca.col_idx, 5);
    tick(); a_start = 1'b1;
    tick(); a_start = 1'b0;
    for (int i = 0; i < 200 && ca.col_idx != 10; i++) tick();
    chk("f2 reach col10", ca.col_idx, 10);
    ca.col_ready = 1'b0;
    for (int i = 0; i < 20 && !ca.col_valid; i++) tick();
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("bp ctl%0d", i),
          {ca.col_valid, a_rd_en, ca.col_idx}, {1'b1, 1'b0, 6'd10});
      chk($sformatf("bp data%0d", i), 480'(ca.col_data),
          exp_col(0, 10, 0));
      tick();
    end
    ca.col_ready = 1'b1;
    tick();
    chk("bp next fetch", {a_rd_en, a_addr, ca.col_idx},
        {1'b1, 12'd22, 6'd11});
    wait_a_done("f2");
    verify_a("f2");

    // Frame 3: reset lands mid-fetch and aborts silently.
    mark_a();
    pulse_a();
    for (int i = 0; i < 200 && !(ca.col_idx == 3 && a_rd_en); i++)
      tick();
    chk("f3 reach fetch3", {ca.col_idx, a_rd_en}, {6'd3, 1'b1});
    rst = 1'b1;
    @(negedge clk);
    chk("midrst ctl", {a_rd_en, a_addr, ca.col_valid, ca.col_idx,
        ca.col_channel, ca.window_valid, ca.out_col, a_busy, a_done}, '0);
    chk("midrst data", ca.col_data, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst no done", a_done_n - a_d0, 0);

    // Frame 4: fresh frame after the abort.
    mark_a();
    pulse_a();
    wait_a_done("f4");
    verify_a("f4");

    // Padded, strided, three-channel frame.
    tick(); b_start = 1'b1;
    tick(); b_start = 1'b0;
    for (int i = 0; i < 1500 && b_done_n == 0; i++) tick();
    repeat (3) tick();
    chk("b done_count", b_done_n, 1);
    chk("b ncols", b_cols.size(), vb.size());
    for (int i = 0; i < vb.size() && i < b_cols.size(); i++) begin
      chk($sformatf("b col%0d meta", i),
          {b_cols[i].ch, b_cols[i].col, b_cols[i].wv,
           b_cols[i].wv ? b_cols[i].oc : 0},
          {vb[i].ch, vb[i].col, vb[i].wv, vb[i].wv ? vb[i].oc : 0});
      chk($sformatf("b col%0d data", i), b_cols[i].data,
          exp_col(vb[i].ch, vb[i].col, 1));
    end
    chk("b nreads", b_reads.size(), 168);
    e = 0;
    for (int c = 0; c < 3; c++)
      for (int x = 0; x < 28; x++)
        for (int w = 0; w < 2; w++) begin
          if (e < b_reads.size())
            chk($sformatf("b read%0d", e),
                {b_reads[e].addr, b_reads[e].col, b_reads[e].ch},
                {(c * 28 + x) * 2 + w, x + 1, c});
          e++;
        end
    f = -1;
    for (int i = 0; i < b_reads.size(); i++)
      if (f < 0 && b_reads[i].ch == 2) f = b_reads[i].addr;
    chk("b ch2 first addr", f, 112);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
